// File: rtl/perf_counter_bank.sv
// perf_counter_bank: nine 16-bit event counters with per-counter clear and edge/level event qualification.
// Optional macro PERF_OVF_EN: counters saturate at 16'hFFFF and raise sticky per-counter overflow flags.
module perf_counter_bank #(
  parameter logic [8:0] EDGE_MASK = 9'h03F
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        count_en,
  input  logic        ev_i_cache_hit,
  input  logic        ev_i_cache_miss,
  input  logic        ev_d_cache_hit,
  input  logic        ev_d_cache_miss,
  input  logic        ev_l2_cache_hit,
  input  logic        ev_l2_cache_miss,
  input  logic        ev_branch,
  input  logic        ev_mispredict,
  input  logic        ev_stall,
  input  logic        clr_i_cache_hits,
  input  logic        clr_i_cache_misses,
  input  logic        clr_d_cache_hits,
  input  logic        clr_d_cache_misses,
  input  logic        clr_l2_cache_hits,
  input  logic        clr_l2_cache_misses,
  input  logic        clr_branches,
  input  logic        clr_mispredicts,
  input  logic        clr_stalls,
  output logic [15:0] i_cache_hits,
  output logic [15:0] i_cache_misses,
  output logic [15:0] d_cache_hits,
  output logic [15:0] d_cache_misses,
  output logic [15:0] l2_cache_hits,
  output logic [15:0] l2_cache_misses,
  output logic [15:0] total_branches,
  output logic [15:0] total_mispredicts,
  output logic [15:0] total_stalls,
  output logic [8:0]  overflow
);

  localparam int NUM_CNT = 9;

  logic [NUM_CNT-1:0] ev_vec;
  logic [NUM_CNT-1:0] clr_vec;
  logic [NUM_CNT-1:0] qual;
  logic [NUM_CNT-1:0] hist_q;
  logic [NUM_CNT-1:0] hist_d;
  logic [15:0]        cnt_q [NUM_CNT];
  logic [15:0]        cnt_d [NUM_CNT];

  assign ev_vec  = {ev_stall, ev_mispredict, ev_branch,
                    ev_l2_cache_miss, ev_l2_cache_hit,
                    ev_d_cache_miss, ev_d_cache_hit,
                    ev_i_cache_miss, ev_i_cache_hit};

  assign clr_vec = {clr_stalls, clr_mispredicts, clr_branches,
                    clr_l2_cache_misses, clr_l2_cache_hits,
                    clr_d_cache_misses, clr_d_cache_hits,
                    clr_i_cache_misses, clr_i_cache_hits};

  // History tracks the raw events every cycle, even while counting is frozen,
  // so a level held across a disable window never produces a late edge.
  assign hist_d = ev_vec;
  assign qual   = ev_vec & ~(hist_q & EDGE_MASK);

`ifdef PERF_OVF_EN
  logic [NUM_CNT-1:0] ovf_q;
  logic [NUM_CNT-1:0] ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr_vec[i]) begin
        cnt_d[i] = 16'h0000;
        ovf_d[i] = 1'b0;
      end else if (count_en && qual[i]) begin
        if (cnt_q[i] == 16'hFFFF) begin
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr_vec[i]) begin
        cnt_d[i] = 16'h0000;
      end else if (count_en && qual[i]) begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  assign overflow = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= '0;
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= 16'h0000;
      end
    end else begin
      hist_q <= hist_d;
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign i_cache_hits      = cnt_q[0];
  assign i_cache_misses    = cnt_q[1];
  assign d_cache_hits      = cnt_q[2];
  assign d_cache_misses    = cnt_q[3];
  assign l2_cache_hits     = cnt_q[4];
  assign l2_cache_misses   = cnt_q[5];
  assign total_branches    = cnt_q[6];
  assign total_mispredicts = cnt_q[7];
  assign total_stalls      = cnt_q[8];

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: randomized and directed stimulus checked every cycle against a counting model.
// Honors PERF_OVF_EN the same way as the design (saturate + sticky flags when defined).
module tb_perf_counter_bank;

  localparam bit [8:0] EDGE_BITS = 9'h03F;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        count_en = 1'b0;
  logic [8:0]  ev = '0;
  logic [8:0]  clr = '0;
  logic [15:0] i_cache_hits, i_cache_misses, d_cache_hits, d_cache_misses;
  logic [15:0] l2_cache_hits, l2_cache_misses, total_branches, total_mispredicts, total_stalls;
  logic [8:0]  overflow;
  logic [15:0] dut_cnt [9];

  int  tests_run = 0;
  int  tests_failed = 0;
  bit  cmp_en = 1'b0;

  int       m_cnt [9];
  bit [8:0] m_prev;
  bit [8:0] m_ovf;

  string cnt_names [9] = '{"i_cache_hits", "i_cache_misses", "d_cache_hits", "d_cache_misses",
                           "l2_cache_hits", "l2_cache_misses", "total_branches",
                           "total_mispredicts", "total_stalls"};

  always #5 clk = ~clk;

  perf_counter_bank dut (
    .clk(clk), .reset_n(reset_n), .count_en(count_en),
    .ev_i_cache_hit(ev[0]), .ev_i_cache_miss(ev[1]), .ev_d_cache_hit(ev[2]),
    .ev_d_cache_miss(ev[3]), .ev_l2_cache_hit(ev[4]), .ev_l2_cache_miss(ev[5]),
    .ev_branch(ev[6]), .ev_mispredict(ev[7]), .ev_stall(ev[8]),
    .clr_i_cache_hits(clr[0]), .clr_i_cache_misses(clr[1]), .clr_d_cache_hits(clr[2]),
    .clr_d_cache_misses(clr[3]), .clr_l2_cache_hits(clr[4]), .clr_l2_cache_misses(clr[5]),
    .clr_branches(clr[6]), .clr_mispredicts(clr[7]), .clr_stalls(clr[8]),
    .i_cache_hits(i_cache_hits), .i_cache_misses(i_cache_misses),
    .d_cache_hits(d_cache_hits), .d_cache_misses(d_cache_misses),
    .l2_cache_hits(l2_cache_hits), .l2_cache_misses(l2_cache_misses),
    .total_branches(total_branches), .total_mispredicts(total_mispredicts),
    .total_stalls(total_stalls), .overflow(overflow)
  );

  assign dut_cnt[0] = i_cache_hits;
  assign dut_cnt[1] = i_cache_misses;
  assign dut_cnt[2] = d_cache_hits;
  assign dut_cnt[3] = d_cache_misses;
  assign dut_cnt[4] = l2_cache_hits;
  assign dut_cnt[5] = l2_cache_misses;
  assign dut_cnt[6] = total_branches;
  assign dut_cnt[7] = total_mispredicts;
  assign dut_cnt[8] = total_stalls;

  // An event counts if it is high (level counters) or just went high (edge counters).
  function automatic bit qualified(int i);
    if (EDGE_BITS[i]) return ev[i] && !m_prev[i];
    return ev[i];
  endfunction

  // Reference model: integer counts updated from the counting rules each clock.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 9; i++) m_cnt[i] <= 0;
      m_prev <= '0;
      m_ovf  <= '0;
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (clr[i]) begin
          m_cnt[i] <= 0;
          m_ovf[i] <= 1'b0;
        end else if (count_en && qualified(i)) begin
`ifdef PERF_OVF_EN
          if (m_cnt[i] == 65535) m_ovf[i] <= 1'b1;
          else m_cnt[i] <= m_cnt[i] + 1;
`else
          m_cnt[i] <= (m_cnt[i] + 1) % 65536;
`endif
        end
      end
      m_prev <= ev;
    end
  end

  // Every-cycle comparison of all counters and the overflow vector against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 9; i++) begin
        tests_run++;
        if (dut_cnt[i] !== 16'(m_cnt[i])) begin
          tests_failed++;
          $display("[TB] FAIL %s at %0t: got %h expected %h", cnt_names[i], $time,
                   dut_cnt[i], 16'(m_cnt[i]));
        end
      end
      tests_run++;
      if (overflow !== m_ovf) begin
        tests_failed++;
        $display("[TB] FAIL overflow at %0t: got %h expected %h", $time, overflow, m_ovf);
      end
    end
  end

  task automatic applyStimulus(input logic [8:0] e, input logic [8:0] c, input logic en);
    @(negedge clk);
    ev       = e;
    clr      = c;
    count_en = en;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic clearAll();
    applyStimulus(9'h000, 9'h1FF, 1'b1);
    applyStimulus(9'h000, 9'h000, 1'b1);
  endtask

  task automatic resetMidCycle();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 9; i++) checkOutput({"reset_async_", cnt_names[i]}, dut_cnt[i], 16'h0000);
    checkOutput("reset_async_overflow", {7'd0, overflow}, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1 checkOutput("reset_hold_i_cache_hits", i_cache_hits, 16'h0000);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    cmp_en = 1'b1;

    // Reset while events are active, released with events still high.
    for (int k = 0; k < 4; k++) applyStimulus(9'h1FF, 9'h000, 1'b1);
    resetMidCycle();
    applyStimulus(9'h1FF, 9'h000, 1'b1);
    applyStimulus(9'h1FF, 9'h000, 1'b1);
    checkOutput("release_edge_i_cache_hits", i_cache_hits, 16'd1);
    checkOutput("release_level_stalls", total_stalls, 16'd1);
    applyStimulus(9'h1FF, 9'h000, 1'b1);
    checkOutput("release_held_i_cache_hits", i_cache_hits, 16'd1);
    checkOutput("release_level_stalls_2", total_stalls, 16'd2);

    // Edge versus level counting.
    clearAll();
    for (int k = 0; k < 5; k++) applyStimulus(9'h001, 9'h000, 1'b1);
    applyStimulus(9'h000, 9'h000, 1'b1);
    for (int k = 0; k < 3; k++) applyStimulus(9'h001, 9'h000, 1'b1);
    applyStimulus(9'h000, 9'h000, 1'b1);
    checkOutput("edge_i_cache_hits", i_cache_hits, 16'd2);
    for (int k = 0; k < 7; k++) applyStimulus(9'h100, 9'h000, 1'b1);
    applyStimulus(9'h000, 9'h000, 1'b1);
    checkOutput("level_stalls", total_stalls, 16'd7);

    // Clear beats a same-cycle event; a level held through clear does not recount.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(9'h008, 9'h000, 1'b1);
      applyStimulus(9'h000, 9'h000, 1'b1);
    end
    checkOutput("d_miss_count5", d_cache_misses, 16'd5);
    applyStimulus(9'h008, 9'h008, 1'b1);
    applyStimulus(9'h000, 9'h000, 1'b1);
    checkOutput("clr_priority", d_cache_misses, 16'd0);
    applyStimulus(9'h008, 9'h000, 1'b1);
    applyStimulus(9'h000, 9'h000, 1'b1);
    checkOutput("after_clr_edge", d_cache_misses, 16'd1);
    applyStimulus(9'h008, 9'h008, 1'b1);
    applyStimulus(9'h008, 9'h000, 1'b1);
    applyStimulus(9'h000, 9'h000, 1'b1);
    checkOutput("held_through_clr", d_cache_misses, 16'd0);

    // Global disable freezes counting while edge history keeps tracking.
    clearAll();
    for (int k = 0; k < 4; k++) applyStimulus(9'h050, 9'h000, 1'b0);
    applyStimulus(9'h050, 9'h000, 1'b1);
    checkOutput("disabled_branches", total_branches, 16'd0);
    checkOutput("disabled_l2_hits", l2_cache_hits, 16'd0);
    applyStimulus(9'h000, 9'h000, 1'b1);
    checkOutput("reenable_branches", total_branches, 16'd1);
    checkOutput("reenable_held_l2_hits", l2_cache_hits, 16'd0);

    // All nine at once, then clear all nine.
    clearAll();
    applyStimulus(9'h1FF, 9'h000, 1'b1);
    applyStimulus(9'h000, 9'h000, 1'b1);
    for (int i = 0; i < 9; i++) checkOutput({"all_one_", cnt_names[i]}, dut_cnt[i], 16'd1);
    applyStimulus(9'h000, 9'h1FF, 1'b1);
    applyStimulus(9'h000, 9'h000, 1'b1);
    for (int i = 0; i < 9; i++) checkOutput({"all_clr_", cnt_names[i]}, dut_cnt[i], 16'd0);

    // Top-of-range behaviour on the stall counter (level mode, one event per cycle).
    for (int k = 0; k < 65534; k++) applyStimulus(9'h100, 9'h000, 1'b1);
    applyStimulus(9'h100, 9'h000, 1'b1);
    checkOutput("preload_fffe", total_stalls, 16'hFFFE);
    applyStimulus(9'h100, 9'h000, 1'b1);
    checkOutput("reach_ffff", total_stalls, 16'hFFFF);
    applyStimulus(9'h000, 9'h000, 1'b1);
`ifdef PERF_OVF_EN
    checkOutput("saturate_stalls", total_stalls, 16'hFFFF);
    checkOutput("overflow_flags", {7'd0, overflow}, 16'h0100);
`else
    checkOutput("wrap_stalls", total_stalls, 16'h0000);
    checkOutput("overflow_flags", {7'd0, overflow}, 16'h0000);
`endif
    applyStimulus(9'h000, 9'h100, 1'b1);
    applyStimulus(9'h000, 9'h000, 1'b1);
    checkOutput("clr_after_top_stalls", total_stalls, 16'h0000);
    checkOutput("clr_after_top_overflow", {7'd0, overflow}, 16'h0000);

    // Random traffic with sparse clears, occasional disable and reset.
    for (int k = 0; k < 4000; k++) begin
      if (k % 700 == 350) resetMidCycle();
      applyStimulus(9'($urandom),
                    9'($urandom & $urandom & $urandom & $urandom),
                    ($urandom_range(0, 7) != 0));
    end
    applyStimulus(9'h000, 9'h000, 1'b1);
    applyStimulus(9'h000, 9'h000, 1'b1);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
